// File: rtl/kolibri_spi.sv
// kolibri_spi: mode-0 SPI byte engine fed by one-cycle $FExx write strobes in the 48 MHz domain.
// Shifts DIN out MSB first on SCLK/MOSI while capturing synchronized MISO into DOUT.
//
// state | meaning
// IDLE  | no transfer; SCLK low, MOSI high, waiting for WR_DATA
// LOW   | SCLK low phase of the current bit, MOSI holds the bit
// HIGH  | SCLK high phase; MISO shifted in on the edge that ends it
module kolibri_spi #(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 59
) (
  input  logic       MHZ48,
  input  logic       nRES,
  input  logic       WR_DATA,
  input  logic       WR_DIV,
  input  logic [7:0] DIN,
  input  logic       MISO,
  output logic       SCLK,
  output logic       MOSI,
  output logic [7:0] DOUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] hm1_q, hm1_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bits_q, bits_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             miso_s1_q, miso_s1_d;
  logic             miso_s2_q, miso_s2_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [7:0]       dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    hm1_d     = hm1_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    miso_s1_d = MISO;
    miso_s2_d = miso_s1_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    dout_d    = dout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q;

    // A new divider only lands in div; the running byte keeps its latched half-period.
    if (WR_DIV) div_d = DIV_W'(DIN);

    case (state_q)
      IDLE: begin
        if (WR_DATA) begin
          hm1_d   = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
          cnt_d   = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
          tx_d    = DIN;
          rx_d    = 8'h00;
          bits_d  = 3'd7;
          mosi_d  = DIN[7];
          busy_d  = 1'b1;
          ovr_d   = 1'b0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          cnt_d   = hm1_q;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          rx_d   = {rx_q[6:0], miso_s2_q};
          sclk_d = 1'b0;
          if (bits_q != 3'd0) begin
            bits_d  = bits_q - 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
            cnt_d   = hm1_q;
            state_d = LOW;
          end else begin
            mosi_d  = 1'b1;
            busy_d  = 1'b0;
            dout_d  = {rx_q[6:0], miso_s2_q};
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (WR_DATA && (state_q != IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge MHZ48 or negedge nRES) begin
    if (!nRES) begin
      state_q   <= IDLE;
      div_q     <= DIV_W'(DIV_RST);
      hm1_q     <= '0;
      cnt_q     <= '0;
      bits_q    <= 3'd0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      dout_q    <= 8'hFF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      hm1_q     <= hm1_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      miso_s1_q <= miso_s1_d;
      miso_s2_q <= miso_s2_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign DOUT = dout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign OVR  = ovr_q;

endmodule
